// File: rtl/hdmi_link_pkg.sv
// Shared definitions for the HDMI source link-management sequencer.
package hdmi_link_pkg;

    // Sequencer states.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_RETIMER,
        ST_VERSION,
        ST_TMDS,
        ST_SETTLE,
        ST_RUN,
        ST_POLL,
        ST_FAIL
    } state_t;

    localparam logic [6:0]  SCDC_ADDRESS              = 7'h54;
    localparam logic [7:0]  SCDC_REG_VERSION          = 8'h02;
    localparam logic [7:0]  SCDC_REG_TMDS_CONFIG      = 8'h20;
    localparam logic [7:0]  SCDC_REG_SCRAMBLER_STATUS = 8'h21;
    localparam logic [7:0]  SCDC_VERSION_VALUE        = 8'h01;
    localparam logic [31:0] HIGH_RATE_THRESHOLD       = 32'd340_000_000;

    // One request on the I2C master interface.
    typedef struct packed {
        logic [6:0] address;
        logic       rw;
        logic [7:0] register_index;
        logic [7:0] data;
    } i2c_req_t;

    function automatic i2c_req_t write_req(input logic [6:0] addr, input logic [7:0] reg_idx,
                                           input logic [7:0] wdata);
        write_req = '{address: addr, rw: 1'b0, register_index: reg_idx, data: wdata};
    endfunction

    function automatic i2c_req_t read_req(input logic [6:0] addr, input logic [7:0] reg_idx);
        read_req = '{address: addr, rw: 1'b1, register_index: reg_idx, data: 8'h00};
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond timer: tick prescaler plus loadable down-counter with a sticky expiry flag.
module ms_timer #(
    parameter int unsigned TICK_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    output logic        expired
);
    localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);

    logic [31:0] cycle_count;
    logic [15:0] ms_count;

    // The load cycle counts as the first prescaler cycle so the period is value*TICK_CYCLES.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= 32'd0;
            ms_count    <= 16'd0;
            expired     <= 1'b0;
        end else if (load) begin
            cycle_count <= 32'd1;
            ms_count    <= value;
            expired     <= (value == 16'd0);
        end else if (ms_count != 16'd0) begin
            if (cycle_count >= TICK_LAST) begin
                cycle_count <= 32'd0;
                ms_count    <= ms_count - 16'd1;
                if (ms_count == 16'd1) begin
                    expired <= 1'b1;
                end
            end else begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end

endmodule

// File: rtl/hdmi_link_controller.sv
// HDMI source link sequencer: HPD debounce, retimer setup, SCDC TMDS config and scrambling watch.
module hdmi_link_controller
    import hdmi_link_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY   = 0,
    parameter logic [6:0]  RETIMER_ADDRESS   = 7'h5E,
    parameter int unsigned RETIMER_REG_COUNT = 9,
    parameter int unsigned HPD_DEBOUNCE_MS   = 100,
    parameter int unsigned SETTLE_MS         = 1,
    parameter int unsigned POLL_MS           = 250,
    parameter int unsigned RETRY_LIMIT       = 3,
    localparam int unsigned TABLE_ENTRIES    = (RETIMER_REG_COUNT > 0) ? RETIMER_REG_COUNT : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          hpd,
    input  logic [16*TABLE_ENTRIES-1:0]   retimer_table,
    input  logic [31:0]                   tmds_clock_frequency,
    output logic                          i2c_ready,
    output logic [6:0]                    i2c_address,
    output logic                          i2c_rw,
    output logic [7:0]                    i2c_register,
    output logic [7:0]                    i2c_data_write,
    input  logic                          i2c_valid,
    input  logic                          i2c_nack,
    input  logic [7:0]                    i2c_data_read,
    output logic                          run,
    output logic                          scrambler_enable,
    output logic                          tmds_bit_clock_ratio,
    output logic                          fail
);
    localparam int unsigned TICK_CYCLES = (CLOCK_FREQUENCY / 1000 > 0) ? CLOCK_FREQUENCY / 1000 : 1;
    localparam int unsigned RETRY_W     = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
    localparam logic [7:0]  LAST_INDEX  = 8'(TABLE_ENTRIES - 1);
    localparam logic [15:0] DEBOUNCE_MS_VALUE = 16'(HPD_DEBOUNCE_MS);
    localparam logic [15:0] SETTLE_MS_VALUE   = 16'(SETTLE_MS);
    localparam logic [15:0] POLL_MS_VALUE     = 16'(POLL_MS);

    state_t             state;
    i2c_req_t           request;
    logic [RETRY_W-1:0] retry;
    logic [7:0]         index;
    logic               timer_load;
    logic [15:0]        timer_value;
    logic               timer_expired;

    logic        done_c, ack_c, retry_c, retry_exhausted_c, high_rate_c, timer_done_c;
    logic [7:0]  next_index_c, tmds_config_c;
    logic [15:0] first_entry_c, next_entry_c;
    logic        unused_read_bits;

    assign done_c            = i2c_ready && i2c_valid;
    assign ack_c             = done_c && !i2c_nack;
    assign high_rate_c       = tmds_clock_frequency > HIGH_RATE_THRESHOLD;
    // Expiry is stale in the cycle the reload is still pending.
    assign timer_done_c      = timer_expired && !timer_load;
    // A NACK is fatal to the attempt everywhere except a low-rate sink without SCDC.
    assign retry_c           = done_c && i2c_nack &&
                               ((state == ST_RETIMER) || (state == ST_TMDS) || (state == ST_POLL) ||
                                ((state == ST_VERSION) && scrambler_enable));
    assign retry_exhausted_c = (32'(retry) + 32'd1) == RETRY_LIMIT;
    assign next_index_c      = index + 8'd1;
    assign first_entry_c     = retimer_table[15:0];
    assign next_entry_c      = retimer_table[16*32'(next_index_c) +: 16];
    assign tmds_config_c     = {6'b0, tmds_bit_clock_ratio, scrambler_enable};
    assign unused_read_bits  = ^i2c_data_read[7:1];

    assign i2c_address    = request.address;
    assign i2c_rw         = request.rw;
    assign i2c_register   = request.register_index;
    assign i2c_data_write = request.data;

    ms_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (timer_load),
        .value   (timer_value),
        .expired (timer_expired)
    );

    // Sequencer with registered I2C request, link status and timer reload.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= ST_IDLE;
            request              <= '0;
            i2c_ready            <= 1'b0;
            run                  <= 1'b0;
            fail                 <= 1'b0;
            scrambler_enable     <= 1'b0;
            tmds_bit_clock_ratio <= 1'b0;
            retry                <= '0;
            index                <= 8'd0;
            timer_load           <= 1'b0;
            timer_value          <= 16'd0;
        end else begin
            timer_load <= 1'b0;
            if ((state != ST_IDLE) && !hpd) begin
                state     <= ST_IDLE;
                i2c_ready <= 1'b0;
                run       <= 1'b0;
                fail      <= 1'b0;
                retry     <= '0;
                index     <= 8'd0;
            end else if (retry_c) begin
                i2c_ready <= 1'b0;
                run       <= 1'b0;
                index     <= 8'd0;
                if (retry_exhausted_c) begin
                    state <= ST_FAIL;
                    fail  <= 1'b1;
                end else begin
                    state       <= ST_DEBOUNCE;
                    retry       <= retry + RETRY_W'(1);
                    timer_load  <= 1'b1;
                    timer_value <= DEBOUNCE_MS_VALUE;
                end
            end else begin
                if (ack_c) begin
                    retry <= '0;
                end
                case (state)
                    ST_IDLE: begin
                        if (hpd) begin
                            state                <= ST_DEBOUNCE;
                            scrambler_enable     <= high_rate_c;
                            tmds_bit_clock_ratio <= high_rate_c;
                            index                <= 8'd0;
                            timer_load           <= 1'b1;
                            timer_value          <= DEBOUNCE_MS_VALUE;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (timer_done_c) begin
                            i2c_ready <= 1'b1;
                            index     <= 8'd0;
                            if (RETIMER_REG_COUNT != 0) begin
                                state   <= ST_RETIMER;
                                request <= write_req(RETIMER_ADDRESS, first_entry_c[15:8], first_entry_c[7:0]);
                            end else begin
                                state   <= ST_VERSION;
                                request <= write_req(SCDC_ADDRESS, SCDC_REG_VERSION, SCDC_VERSION_VALUE);
                            end
                        end
                    end
                    ST_RETIMER: begin
                        if (ack_c) begin
                            if (index == LAST_INDEX) begin
                                state   <= ST_VERSION;
                                request <= write_req(SCDC_ADDRESS, SCDC_REG_VERSION, SCDC_VERSION_VALUE);
                            end else begin
                                index   <= next_index_c;
                                request <= write_req(RETIMER_ADDRESS, next_entry_c[15:8], next_entry_c[7:0]);
                            end
                        end
                    end
                    ST_VERSION: begin
                        if (done_c) begin
                            if (i2c_nack) begin
                                state     <= ST_RUN;
                                run       <= 1'b1;
                                i2c_ready <= 1'b0;
                            end else begin
                                state   <= ST_TMDS;
                                request <= write_req(SCDC_ADDRESS, SCDC_REG_TMDS_CONFIG, tmds_config_c);
                            end
                        end
                    end
                    ST_TMDS: begin
                        if (ack_c) begin
                            state       <= ST_SETTLE;
                            i2c_ready   <= 1'b0;
                            timer_load  <= 1'b1;
                            timer_value <= SETTLE_MS_VALUE;
                        end
                    end
                    ST_SETTLE: begin
                        if (timer_done_c) begin
                            state       <= ST_RUN;
                            run         <= 1'b1;
                            timer_load  <= scrambler_enable;
                            timer_value <= POLL_MS_VALUE;
                        end
                    end
                    ST_RUN: begin
                        if (scrambler_enable && timer_done_c) begin
                            state     <= ST_POLL;
                            i2c_ready <= 1'b1;
                            request   <= read_req(SCDC_ADDRESS, SCDC_REG_SCRAMBLER_STATUS);
                        end
                    end
                    ST_POLL: begin
                        if (ack_c) begin
                            if (i2c_data_read[0]) begin
                                state       <= ST_RUN;
                                i2c_ready   <= 1'b0;
                                timer_load  <= 1'b1;
                                timer_value <= POLL_MS_VALUE;
                            end else begin
                                state   <= ST_TMDS;
                                run     <= 1'b0;
                                request <= write_req(SCDC_ADDRESS, SCDC_REG_TMDS_CONFIG, tmds_config_c);
                            end
                        end
                    end
                    ST_FAIL: begin
                        i2c_ready <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdmi_link_controller.sv
// Scoreboard bench for hdmi_link_controller with a simple I2C responder model.
module tb_hdmi_link_controller;
    localparam int unsigned REG_COUNT = 9;
    localparam int          LATENCY   = 1;

    typedef struct packed {
        logic [6:0] address;
        logic       rw;
        logic [7:0] register_index;
        logic [7:0] data;
    } txn_t;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    hpd;
    logic [16*REG_COUNT-1:0] retimer_table;
    logic [31:0]             tmds_clock_frequency;
    logic                    i2c_ready;
    logic [6:0]              i2c_address;
    logic                    i2c_rw;
    logic [7:0]              i2c_register;
    logic [7:0]              i2c_data_write;
    logic                    i2c_valid;
    logic                    i2c_nack;
    logic [7:0]              i2c_data_read;
    logic                    run;
    logic                    scrambler_enable;
    logic                    tmds_bit_clock_ratio;
    logic                    fail;

    logic        hpd0;
    logic [15:0] retimer_table0;
    logic        i2c_ready0, i2c_rw0, run0, scrambler_enable0, tmds_bit_clock_ratio0, fail0;
    logic [6:0]  i2c_address0;
    logic [7:0]  i2c_register0, i2c_data_write0;
    logic        i2c_valid0 = 1'b0;
    logic        i2c_nack0 = 1'b0;
    logic [7:0]  i2c_data_read0 = 8'h00;

    txn_t       exp_q[$];
    logic [7:0] poll_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic       nack_retimer = 1'b0;
    logic       nack_version = 1'b0;
    logic       poll_gap_en = 1'b0;
    int         last_poll_cyc = -1;
    logic       mon_ready_q = 1'b0;
    logic       mon_valid_q = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    hdmi_link_controller #(
        .CLOCK_FREQUENCY(10_000), .RETIMER_ADDRESS(7'h5E), .RETIMER_REG_COUNT(REG_COUNT),
        .HPD_DEBOUNCE_MS(2), .SETTLE_MS(1), .POLL_MS(3), .RETRY_LIMIT(3)
    ) dut (
        .clock(clock), .reset(reset), .hpd(hpd), .retimer_table(retimer_table),
        .tmds_clock_frequency(tmds_clock_frequency), .i2c_ready(i2c_ready),
        .i2c_address(i2c_address), .i2c_rw(i2c_rw), .i2c_register(i2c_register),
        .i2c_data_write(i2c_data_write), .i2c_valid(i2c_valid), .i2c_nack(i2c_nack),
        .i2c_data_read(i2c_data_read), .run(run), .scrambler_enable(scrambler_enable),
        .tmds_bit_clock_ratio(tmds_bit_clock_ratio), .fail(fail)
    );

    hdmi_link_controller #(
        .CLOCK_FREQUENCY(10_000), .RETIMER_ADDRESS(7'h5E), .RETIMER_REG_COUNT(0),
        .HPD_DEBOUNCE_MS(2), .SETTLE_MS(1), .POLL_MS(3), .RETRY_LIMIT(3)
    ) dut0 (
        .clock(clock), .reset(reset), .hpd(hpd0), .retimer_table(retimer_table0),
        .tmds_clock_frequency(tmds_clock_frequency), .i2c_ready(i2c_ready0),
        .i2c_address(i2c_address0), .i2c_rw(i2c_rw0), .i2c_register(i2c_register0),
        .i2c_data_write(i2c_data_write0), .i2c_valid(i2c_valid0), .i2c_nack(i2c_nack0),
        .i2c_data_read(i2c_data_read0), .run(run0), .scrambler_enable(scrambler_enable0),
        .tmds_bit_clock_ratio(tmds_bit_clock_ratio0), .fail(fail0)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int value, input int lo, input int hi);
        checks++;
        if (value < lo || value > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, value, lo, hi);
        end
    endtask

    task automatic push_write(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d);
        exp_q.push_back('{a, 1'b0, r, d});
    endtask

    task automatic push_read(input logic [6:0] a, input logic [7:0] r);
        exp_q.push_back('{a, 1'b1, r, 8'h00});
    endtask

    task automatic push_table(input int first, input int last);
        for (int i = first; i <= last; i++) push_write(7'h5E, 8'h10 + 8'(i), 8'hA0 + 8'(i));
    endtask

    task automatic wait_run(input logic level, input int budget, input string name);
        int n = 0;
        while (run !== level && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(run), 32'(level));
    endtask

    task automatic wait_queue_empty(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // I2C slave model: accepts a request, answers LATENCY+1 cycles later.
    initial begin
        logic       busy;
        int         wait_cnt;
        logic       resp_nack;
        logic [7:0] resp_data;
        busy = 1'b0; wait_cnt = 0; resp_nack = 1'b0; resp_data = 8'h00;
        i2c_valid = 1'b0; i2c_nack = 1'b0; i2c_data_read = 8'h00;
        forever begin
            @(posedge clock);
            #1;
            i2c_valid = 1'b0; i2c_nack = 1'b0; i2c_data_read = 8'h00;
            if (busy) begin
                if (wait_cnt == 0) begin
                    i2c_valid = 1'b1; i2c_nack = resp_nack; i2c_data_read = resp_data; busy = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else if (i2c_ready) begin
                busy = 1'b1;
                wait_cnt = LATENCY;
                resp_nack = (i2c_address == 7'h5E && nack_retimer) ||
                            (i2c_address == 7'h54 && i2c_register == 8'h02 && nack_version);
                resp_data = 8'h00;
                if (i2c_rw) resp_data = (poll_q.size() > 0) ? poll_q.pop_front() : 8'h01;
            end
        end
    end

    // Monitor: every newly presented request is compared with the scoreboard head.
    initial begin
        txn_t got;
        txn_t expv;
        forever begin
            @(negedge clock);
            if (i2c_ready && (!mon_ready_q || mon_valid_q)) begin
                got = '{i2c_address, i2c_rw, i2c_register, i2c_rw ? 8'h00 : i2c_data_write};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_txn: got 0x%0h, expected none", got);
                end else begin
                    expv = exp_q.pop_front();
                    check("i2c_txn", 32'(got), 32'(expv));
                end
                if (poll_gap_en && i2c_rw) begin
                    if (last_poll_cyc >= 0) check_range("poll_interval", cyc - last_poll_cyc, 30, 36);
                    last_poll_cyc = cyc;
                end
            end
            mon_ready_q = i2c_ready;
            mon_valid_q = i2c_valid;
        end
    end

    // Directed scenarios.
    initial begin
        int   n;
        logic last_v;
        reset = 1'b1; hpd = 1'b0; hpd0 = 1'b0; retimer_table0 = 16'h0000;
        tmds_clock_frequency = 32'd594_000_000;
        for (int i = 0; i < int'(REG_COUNT); i++) retimer_table[16*i +: 16] = {8'h10 + 8'(i), 8'hA0 + 8'(i)};
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_ready", 32'(i2c_ready), 32'd0);
        check("reset_run", 32'(run), 32'd0);
        check("reset_fail", 32'(fail), 32'd0);
        check("reset_scramble", 32'({scrambler_enable, tmds_bit_clock_ratio}), 32'd0);

        // Nominal 594 MHz bring-up with periodic polling.
        push_table(0, 8);
        push_write(7'h54, 8'h02, 8'h01);
        push_write(7'h54, 8'h20, 8'h03);
        hpd = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (!i2c_ready && n < 100);
        check_range("debounce_cycles", n, 20, 22);
        wait_run(1'b1, 200, "nominal_run_up");
        check("nominal_scramble", 32'({scrambler_enable, tmds_bit_clock_ratio}), 32'h3);
        last_poll_cyc = -1;
        poll_gap_en = 1'b1;
        repeat (3) push_read(7'h54, 8'h21);
        wait_queue_empty(150, "nominal_polls");
        check("nominal_run_hold", 32'(run), 32'd1);
        poll_gap_en = 1'b0;
        hpd = 1'b0;
        @(negedge clock);
        check("hpd_drop", 32'({i2c_ready, run}), 32'd0);
        repeat (6) @(negedge clock);

        // Scrambling loss: status 0x00 forces a config rewrite and re-settle.
        push_table(0, 8);
        push_write(7'h54, 8'h02, 8'h01);
        push_write(7'h54, 8'h20, 8'h03);
        push_read(7'h54, 8'h21);
        push_write(7'h54, 8'h20, 8'h03);
        push_read(7'h54, 8'h21);
        poll_q.push_back(8'h00);
        poll_q.push_back(8'h01);
        hpd = 1'b1;
        wait_run(1'b1, 200, "loss_run_up");
        wait_run(1'b0, 60, "loss_run_drop");
        wait_run(1'b1, 60, "loss_run_recover");
        wait_queue_empty(60, "loss_txns");
        check("loss_run_hold", 32'(run), 32'd1);
        hpd = 1'b0;
        repeat (6) @(negedge clock);

        // 148.5 MHz sink without SCDC: run straight after the NACKed version write.
        tmds_clock_frequency = 32'd148_500_000;
        nack_version = 1'b1;
        push_table(0, 8);
        push_write(7'h54, 8'h02, 8'h01);
        hpd = 1'b1;
        n = 0;
        last_v = 1'b0;
        while (!run && n < 200) begin
            last_v = i2c_valid;
            @(negedge clock);
            n++;
        end
        check("lowrate_run", 32'(run), 32'd1);
        check("lowrate_run_after_valid", 32'(last_v), 32'd1);
        check("lowrate_scramble", 32'({scrambler_enable, tmds_bit_clock_ratio}), 32'd0);
        repeat (80) @(negedge clock);
        check("lowrate_no_more_txns", 32'(exp_q.size()), 32'd0);
        check("lowrate_run_hold", 32'(run), 32'd1);
        hpd = 1'b0;
        nack_version = 1'b0;
        repeat (6) @(negedge clock);

        // Persistent retimer NACK: three debounced attempts then FAIL.
        tmds_clock_frequency = 32'd594_000_000;
        nack_retimer = 1'b1;
        repeat (3) push_write(7'h5E, 8'h10, 8'hA0);
        hpd = 1'b1;
        n = 0;
        while (!fail && n < 300) begin @(negedge clock); n++; end
        check("retry_fail", 32'(fail), 32'd1);
        check_range("retry_fail_cycles", n, 67, 73);
        check("retry_attempts", 32'(exp_q.size()), 32'd0);
        repeat (10) @(negedge clock);
        check("fail_hold", 32'({fail, i2c_ready, run}), 32'h4);
        hpd = 1'b0;
        @(negedge clock);
        check("fail_clear", 32'(fail), 32'd0);
        nack_retimer = 1'b0;
        repeat (6) @(negedge clock);

        // HPD glitch during table entry 2 restarts from entry 0.
        push_table(0, 2);
        hpd = 1'b1;
        n = 0;
        while (!(i2c_ready && i2c_register == 8'h12) && n < 200) begin @(negedge clock); n++; end
        check("glitch_reached_entry2", 32'(i2c_register), 32'h12);
        hpd = 1'b0;
        @(negedge clock);
        check("glitch_ready_drop", 32'(i2c_ready), 32'd0);
        repeat (4) @(negedge clock);
        push_table(0, 8);
        push_write(7'h54, 8'h02, 8'h01);
        push_write(7'h54, 8'h20, 8'h03);
        hpd = 1'b1;
        wait_run(1'b1, 300, "glitch_recover");
        check("glitch_txns", 32'(exp_q.size()), 32'd0);
        hpd = 1'b0;
        repeat (6) @(negedge clock);

        // Empty retimer table: SCDC version write right after debounce.
        hpd0 = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (!i2c_ready0 && n < 100);
        check_range("notable_debounce_cycles", n, 20, 22);
        check("notable_first_txn", 32'({i2c_address0, i2c_rw0, i2c_register0, i2c_data_write0}),
              32'({7'h54, 1'b0, 8'h02, 8'h01}));
        check("notable_status", 32'({run0, fail0, scrambler_enable0, tmds_bit_clock_ratio0}), 32'h3);
        hpd0 = 1'b0;
        repeat (3) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
